// File: rtl/result_readout_if.sv
// Host-facing bundle for the result drain path: array-side capture inputs,
// host fetch request, and the byte-serial output stream back to the host.
interface result_readout_if #(
   parameter int RESULT_W = 16
);
   logic                store_result;
   logic [RESULT_W-1:0] result1;
   logic [RESULT_W-1:0] result2;
   logic [RESULT_W-1:0] result3;
   logic [RESULT_W-1:0] result4;
   logic                fetch_r;
   logic [7:0]          uo_out;
   logic                out_valid;
   logic                busy;
   logic                has_data;
   logic                done;

   modport master (
      output store_result, result1, result2, result3, result4, fetch_r,
      input  uo_out, out_valid, busy, has_data, done
   );

   modport slave (
      input  store_result, result1, result2, result3, result4, fetch_r,
      output uo_out, out_valid, busy, has_data, done
   );
endinterface

// File: rtl/result_readout.sv
// Captures four accumulator results and streams them to the host one byte per
// slot, low byte of result1 first, with optional idle gaps between bytes.
//
//   state | meaning
//   IDLE  | waiting; store_result captures, fetch_r starts a stream if has_data
//   SEND  | a byte is valid on uo_out this cycle
//   GAP   | idle spacing between bytes; uo_out holds the previous byte
module result_readout #(
   parameter int RESULT_W   = 16,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset,
   result_readout_if.slave  bus
);
   localparam int BYTES_PER_RESULT = RESULT_W / 8;
   localparam int N_BYTES          = 4 * BYTES_PER_RESULT;
   localparam int SEL_W            = $clog2(N_BYTES);

   localparam logic [SEL_W:0] IDX_END  = (SEL_W+1)'(N_BYTES);
   localparam logic [SEL_W:0] IDX_ONE  = (SEL_W+1)'(1);
   localparam logic [2:0]     GAP_LOAD = 3'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [N_BYTES-1:0][7:0] res_q, res_d;
   logic [SEL_W:0]          idx_q, idx_d;
   logic [2:0]              gap_q, gap_d;
   logic [7:0]              uo_q, uo_d;
   logic                    valid_q, valid_d;
   logic                    busy_q, busy_d;
   logic                    has_q, has_d;
   logic                    done_q, done_d;
   logic [7:0]              next_byte;

   // idx_q always points at the next byte to drive; it only reaches IDX_END
   // after the last byte has been driven, and the select is not used then.
   assign next_byte = res_q[idx_q[SEL_W-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         res_q   <= '0;
         idx_q   <= '0;
         gap_q   <= '0;
         uo_q    <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         has_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         uo_q    <= uo_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         has_q   <= has_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      uo_d    = uo_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      has_d   = has_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // A store on the same edge as a fetch wins; the host must re-request.
            if (bus.store_result) begin
               res_d = {bus.result4, bus.result3, bus.result2, bus.result1};
               has_d = 1'b1;
            end else if (bus.fetch_r && has_q) begin
               uo_d    = res_q[0];
               valid_d = 1'b1;
               busy_d  = 1'b1;
               idx_d   = IDX_ONE;
               state_d = SEND;
            end
         end
         SEND: begin
            if (idx_q == IDX_END) begin
               uo_d    = '0;
               busy_d  = 1'b0;
               has_d   = 1'b0;
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end else if (GAP_CYCLES == 0) begin
               uo_d    = next_byte;
               valid_d = 1'b1;
               idx_d   = idx_q + IDX_ONE;
            end else begin
               gap_d   = GAP_LOAD;
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_q == 3'd0) begin
               uo_d    = next_byte;
               valid_d = 1'b1;
               idx_d   = idx_q + IDX_ONE;
               state_d = SEND;
            end else begin
               gap_d = gap_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.uo_out    = uo_q;
   assign bus.out_valid = valid_q;
   assign bus.busy      = busy_q;
   assign bus.has_data  = has_q;
   assign bus.done      = done_q;
endmodule
